sprite_compositor: RTL and testbench

//  N-layer sprite/background pixel compositor for the VGA path, sitting between the game-state logic and the VGA DAC.
//  Per pixel it hit-tests N rectangular sprites, generates animation-aware sprite ROM addresses and resolves priority/transparency.
//  It then looks up 24-bit RGB in a writable palette and reports per-frame sprite-0 collisions.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/palette_ram.sv | 25 ++
 rtl/sprite_compositor.sv | 141 ++++++++++++++
 tb/tb_sprite_compositor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor: RGB pixel struct,
// pipeline depth and the animation-frame base address helper.
package sprite_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int PIPE_LAT       = 3;
    localparam int TRANSP_DEFAULT = 0;

    // Frame selects beyond the ROM's frame count fall back to frame 0
    function automatic int frame_base(input logic [1:0] frame, input int n_frames,
                                      input int w, input int h);
        return (int'(frame) >= n_frames) ? 0 : int'(frame) * w * h;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette memory: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module palette_ram #(
    parameter int AW = 5,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite/background compositor: hit-test and ROM addressing, priority
// and transparency resolve, palette lookup and per-frame sprite-0 collisions.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int N_SPR    = 4,
    parameter int SPR_W    = 35,
    parameter int SPR_H    = 33,
    parameter int N_FRAMES = 3,
    parameter int IDX_W    = 4,
    parameter int ADDR_W   = 19,
    parameter int TRANSP   = TRANSP_DEFAULT
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           pix_en,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           blank,
    input  logic                           vs,
    input  logic [N_SPR-1:0][9:0]          spr_x,
    input  logic [N_SPR-1:0][9:0]          spr_y,
    input  logic [N_SPR-1:0]               spr_act,
    input  logic [N_SPR-1:0][1:0]          spr_frame,
    output logic [N_SPR-1:0][ADDR_W-1:0]   spr_rom_addr,
    input  logic [N_SPR-1:0][IDX_W-1:0]    spr_rom_data,
    input  logic [IDX_W-1:0]               bg_idx,
    input  logic                           pal_we,
    input  logic [IDX_W:0]                 pal_waddr,
    input  logic [23:0]                    pal_wdata,
    output logic [7:0]                     Red,
    output logic [7:0]                     Green,
    output logic [7:0]                     Blue,
    output logic [N_SPR-1:0]               coll_mask,
    output logic                           frame_done
);

    localparam int PAL_AW = IDX_W + 1;

    logic [N_SPR-1:0]              hit_s0;
    logic [N_SPR-1:0][ADDR_W-1:0]  addr_s0;
    logic [N_SPR-1:0]              hit_d;
    logic [N_SPR-1:0]              opaque;
    logic [N_SPR-1:0]              coll_now;
    logic [N_SPR-1:0]              hits_now;
    logic [N_SPR-1:0]              accum;
    logic [PIPE_LAT-2:0]           blank_pipe;
    logic                          valid_d1;
    logic [PAL_AW-1:0]             pal_raddr;
    logic [23:0]                   pal_rdata;
    rgb_t                          rgb_q;
    logic                          vs_d;
    logic                          vs_dd;
    logic                          vs_fall;

    // 11-bit diffs: a pixel left of/above the sprite goes "negative" and
    // lands far outside the sprite box instead of wrapping back into it
    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
        logic [10:0] dx;
        logic [10:0] dy;
        assign dx = {1'b0, DrawX} - {1'b0, spr_x[i]};
        assign dy = {1'b0, DrawY} - {1'b0, spr_y[i]};
        assign hit_s0[i] = spr_act[i] && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
        assign addr_s0[i] = hit_s0[i]
            ? ADDR_W'(frame_base(spr_frame[i], N_FRAMES, SPR_W, SPR_H)
                      + int'(dy) * SPR_W + int'(dx))
            : '0;
        assign opaque[i] = hit_d[i] && (spr_rom_data[i] != IDX_W'(TRANSP));
    end

    // Lowest-numbered opaque sprite wins; background bank otherwise
    always_comb begin
        pal_raddr = {1'b1, bg_idx};
        coll_now  = '0;
        for (int i = N_SPR - 1; i >= 0; i--)
            if (opaque[i])
                pal_raddr = {1'b0, spr_rom_data[i]};
        for (int i = 1; i < N_SPR; i++)
            coll_now[i] = opaque[i] & opaque[0];
    end

    assign hits_now = (pix_en && valid_d1) ? coll_now : '0;

    palette_ram #(
        .AW (PAL_AW),
        .DW (24)
    ) u_palette (
        .clk   (Clk),
        .we    (pal_we),
        .waddr (pal_waddr),
        .wdata (pal_wdata),
        .re    (pix_en),
        .raddr (pal_raddr),
        .rdata (pal_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            spr_rom_addr <= '0;
            hit_d        <= '0;
            valid_d1     <= 1'b0;
            blank_pipe   <= '0;
            rgb_q        <= '0;
        end else if (pix_en) begin
            spr_rom_addr <= addr_s0;
            hit_d        <= hit_s0;
            valid_d1     <= 1'b1;
            blank_pipe   <= {blank_pipe[PIPE_LAT-3:0], blank};
            rgb_q        <= blank_pipe[PIPE_LAT-2] ? rgb_t'(pal_rdata) : '0;
        end
    end

    assign vs_fall = vs_dd & ~vs_d;

    // Collision accumulation runs on every Clk so a frame edge between
    // pixel beats is never missed
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_d       <= 1'b1;
            vs_dd      <= 1'b1;
            accum      <= '0;
            coll_mask  <= '0;
            frame_done <= 1'b0;
        end else begin
            vs_d       <= vs;
            vs_dd      <= vs_d;
            frame_done <= vs_fall;
            if (vs_fall) begin
                coll_mask <= accum | hits_now;
                accum     <= '0;
            end else begin
                accum <= accum | hits_now;
            end
        end
    end

    assign Red   = rgb_q.r;
    assign Green = rgb_q.g;
    assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: vector table for hit/priority/address
// cases plus hand sequences for latency, stalls, collisions and reset.
module tb_sprite_compositor;

    logic                  Clk;
    logic                  Reset;
    logic                  pix_en;
    logic [9:0]            DrawX;
    logic [9:0]            DrawY;
    logic                  blank;
    logic                  vs;
    logic [3:0][9:0]       spr_x;
    logic [3:0][9:0]       spr_y;
    logic [3:0]            spr_act;
    logic [3:0][1:0]       spr_frame;
    logic [3:0][18:0]      spr_rom_addr;
    logic [3:0][3:0]       spr_rom_data;
    logic [3:0]            bg_idx;
    logic                  pal_we;
    logic [4:0]            pal_waddr;
    logic [23:0]           pal_wdata;
    logic [7:0]            Red;
    logic [7:0]            Green;
    logic [7:0]            Blue;
    logic [3:0]            coll_mask;
    logic                  frame_done;

    logic [3:0]            rom_val [4];
    int                    cmp_cnt;
    int                    fail_cnt;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] GREY  = 24'h777777;
    localparam logic [23:0] S3COL = 24'hABCDEF;

    typedef struct {
        logic [3:0]  act;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [1:0]  frm0;
        logic [3:0]  rom0;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        bl;
        logic [18:0] eaddr;
        logic [23:0] ergb;
    } vec_t;

    vec_t vecs [17];

    sprite_compositor dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .pix_en       (pix_en),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .vs           (vs),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_act      (spr_act),
        .spr_frame    (spr_frame),
        .spr_rom_addr (spr_rom_addr),
        .spr_rom_data (spr_rom_data),
        .bg_idx       (bg_idx),
        .pal_we       (pal_we),
        .pal_waddr    (pal_waddr),
        .pal_wdata    (pal_wdata),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .coll_mask    (coll_mask),
        .frame_done   (frame_done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Sprite ROMs modelled as one opaque/transparent index per layer, 1 Clk latency
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++)
            spr_rom_data[i] <= rom_val[i];
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] rgbOut();
        return {Red, Green, Blue};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        cmp_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic beat();
        @(negedge Clk);
        pix_en = 1'b1;
        @(negedge Clk);
        pix_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic bl);
        DrawX = x;
        DrawY = y;
        blank = bl;
    endtask

    task automatic palWrite(input logic [4:0] a, input logic [23:0] d);
        @(negedge Clk);
        pal_we    = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
        @(negedge Clk);
        pal_we    = 1'b0;
    endtask

    // Drops vs, counts frame_done pulses within a bounded window and
    // returns the mask seen with the pulse
    task automatic frameEnd(output int pulses, output logic [3:0] mask);
        pulses = 0;
        mask   = 4'hX;
        @(negedge Clk);
        vs = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (frame_done) begin
                pulses++;
                mask = coll_mask;
            end
        end
        vs = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic beats(input logic [9:0] x, input logic [9:0] y, input int n);
        applyStimulus(x, y, 1'b1);
        repeat (n) beat();
    endtask

    initial begin
        int          pulses;
        logic [3:0]  mask;
        logic [23:0] lat_exp [6];

        cmp_cnt   = 0;
        fail_cnt  = 0;
        Reset     = 1'b1;
        pix_en    = 1'b0;
        vs        = 1'b1;
        pal_we    = 1'b0;
        pal_waddr = '0;
        pal_wdata = '0;
        bg_idx    = 4'd2;
        spr_act   = 4'hF;
        spr_x[0] = 10'd100; spr_y[0] = 10'd100;
        spr_x[1] = 10'd200; spr_y[1] = 10'd200;
        spr_x[2] = 10'd134; spr_y[2] = 10'd132;
        spr_x[3] = 10'd630; spr_y[3] = 10'd470;
        spr_frame = '0;
        rom_val[0] = 4'd1; rom_val[1] = 4'd3; rom_val[2] = 4'd4; rom_val[3] = 4'd5;
        applyStimulus(10'd0, 10'd0, 1'b1);

        //             act   x0    y0    frm  rom  px    py    bl  addr   rgb
        vecs[0]  = '{4'hF, 100, 100, 2'd0, 4'd1, 100, 100, 1'b1, 0,    RED};
        vecs[1]  = '{4'hF, 100, 100, 2'd0, 4'd1,  99, 100, 1'b1, 0,    BLUE};
        vecs[2]  = '{4'hF, 100, 100, 2'd0, 4'd1, 134, 132, 1'b1, 1154, RED};
        vecs[3]  = '{4'hF, 100, 100, 2'd0, 4'd1, 135, 100, 1'b1, 0,    BLUE};
        vecs[4]  = '{4'hF, 100, 100, 2'd0, 4'd1, 100, 133, 1'b1, 0,    BLUE};
        vecs[5]  = '{4'hF, 200, 200, 2'd0, 4'd1, 200, 200, 1'b1, 0,    RED};
        vecs[6]  = '{4'hF, 200, 200, 2'd0, 4'd0, 201, 201, 1'b1, 36,   GREEN};
        vecs[7]  = '{4'hF, 100, 100, 2'd2, 4'd1, 102, 101, 1'b1, 2347, RED};
        vecs[8]  = '{4'hF, 100, 100, 2'd3, 4'd1, 102, 101, 1'b1, 37,   RED};
        vecs[9]  = '{4'hF, 100, 100, 2'd1, 4'd1, 134, 132, 1'b1, 2309, RED};
        vecs[10] = '{4'hE, 100, 100, 2'd0, 4'd1, 100, 100, 1'b1, 0,    BLUE};
        vecs[11] = '{4'hF, 100, 100, 2'd0, 4'd1, 101, 100, 1'b0, 1,    24'h0};
        vecs[12] = '{4'hF, 620, 450, 2'd0, 4'd1, 639, 460, 1'b1, 369,  RED};
        vecs[13] = '{4'hF, 620, 450, 2'd0, 4'd1,   0, 460, 1'b1, 0,    BLUE};
        vecs[14] = '{4'hF, 1010,  0, 2'd0, 4'd1,   5,  10, 1'b1, 0,    BLUE};
        vecs[15] = '{4'h8, 100, 100, 2'd0, 4'd1, 639, 479, 1'b1, 0,    S3COL};
        vecs[16] = '{4'hF, 100, 100, 2'd0, 4'd2, 100, 100, 1'b1, 0,    GREY};

        repeat (3) @(negedge Clk);
        checkOutput("reset addr0", 32'(spr_rom_addr[0]), 0);
        checkOutput("reset rgb", 32'(rgbOut()), 0);
        checkOutput("reset coll_mask", 32'(coll_mask), 0);
        checkOutput("reset frame_done", 32'(frame_done), 0);
        @(negedge Clk);
        Reset = 1'b0;

        palWrite(5'h01, RED);
        palWrite(5'h02, GREY);
        palWrite(5'h03, GREEN);
        palWrite(5'h04, 24'h123456);
        palWrite(5'h05, S3COL);
        palWrite(5'h12, BLUE);

        for (int i = 0; i < 17; i++) begin
            spr_act      = vecs[i].act;
            spr_x[0]     = vecs[i].x0;
            spr_y[0]     = vecs[i].y0;
            spr_frame[0] = vecs[i].frm0;
            rom_val[0]   = vecs[i].rom0;
            applyStimulus(vecs[i].px, vecs[i].py, vecs[i].bl);
            beat();
            checkOutput($sformatf("vec%0d addr0", i), 32'(spr_rom_addr[0]), 32'(vecs[i].eaddr));
            beat();
            beat();
            checkOutput($sformatf("vec%0d rgb", i), 32'(rgbOut()), 32'(vecs[i].ergb));
        end

        spr_act = 4'hF; spr_x[0] = 10'd100; spr_y[0] = 10'd100;
        spr_frame[0] = 2'd0; rom_val[0] = 4'd1;

        // One pixel per beat: RGB must trail DrawX/Y by exactly three beats
        beats(10'd0, 10'd0, 3);
        lat_exp = '{BLUE, BLUE, RED, BLUE, 24'h0, RED};
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       applyStimulus(10'd100, 10'd100, 1'b1);
                1:       applyStimulus(10'd99, 10'd100, 1'b1);
                2:       applyStimulus(10'd100, 10'd100, 1'b0);
                default: applyStimulus(10'd100, 10'd100, 1'b1);
            endcase
            beat();
            checkOutput($sformatf("latency beat%0d rgb", k), 32'(rgbOut()), 32'(lat_exp[k]));
        end

        // Stall: pix_en low for 5 Clk with DrawX moving must freeze everything
        beats(10'd99, 10'd100, 3);
        beats(10'd102, 10'd101, 1);
        checkOutput("stall pre addr0", 32'(spr_rom_addr[0]), 37);
        applyStimulus(10'd0, 10'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            checkOutput($sformatf("stall clk%0d addr0", c), 32'(spr_rom_addr[0]), 37);
            checkOutput($sformatf("stall clk%0d rgb", c), 32'(rgbOut()), 32'(BLUE));
        end
        beats(10'd103, 10'd101, 1);
        checkOutput("stall post addr0", 32'(spr_rom_addr[0]), 38);
        checkOutput("stall post rgb", 32'(rgbOut()), 32'(BLUE));
        beat();
        checkOutput("stall resume rgb", 32'(rgbOut()), 32'(RED));

        // Collisions: flush whatever the vectors accumulated, then overlap s0/s2
        beats(10'd0, 10'd0, 3);
        frameEnd(pulses, mask);
        checkOutput("flush frame pulses", 32'(pulses), 1);
        beats(10'd134, 10'd132, 2);
        beats(10'd0, 10'd0, 3);
        frameEnd(pulses, mask);
        checkOutput("overlap frame pulses", 32'(pulses), 1);
        checkOutput("overlap frame mask", 32'(mask), 32'h4);
        beats(10'd100, 10'd100, 3);
        beats(10'd0, 10'd0, 3);
        frameEnd(pulses, mask);
        checkOutput("clear frame pulses", 32'(pulses), 1);
        checkOutput("clear frame mask", 32'(mask), 0);
        beats(10'd134, 10'd132, 2);
        beats(10'd0, 10'd0, 3);
        frameEnd(pulses, mask);
        checkOutput("overlap2 frame mask", 32'(mask), 32'h4);

        // Mid-line reset with a pending collision and a live sprite pixel
        beats(10'd134, 10'd132, 2);
        beats(10'd102, 10'd101, 3);
        checkOutput("pre-reset rgb", 32'(rgbOut()), 32'(RED));
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async reset rgb", 32'(rgbOut()), 0);
        checkOutput("async reset addr0", 32'(spr_rom_addr[0]), 0);
        checkOutput("async reset coll_mask", 32'(coll_mask), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        beat();
        checkOutput("post-reset beat1 addr0", 32'(spr_rom_addr[0]), 37);
        checkOutput("post-reset beat1 rgb", 32'(rgbOut()), 0);
        beat();
        checkOutput("post-reset beat2 rgb", 32'(rgbOut()), 0);
        beat();
        checkOutput("post-reset beat3 rgb", 32'(rgbOut()), 32'(RED));
        frameEnd(pulses, mask);
        checkOutput("post-reset frame pulses", 32'(pulses), 1);
        checkOutput("post-reset frame mask", 32'(mask), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
